// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter.
// Holds the FSM state encoding, the port identifiers and the default
// watchdog length used by mem_arbiter when MEM_ARB_TIMEOUT_EN is defined.

package mem_arb_pkg;

  // Arbiter FSM states: pick a winner, wait for memory, answer the winner.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arbState_e;

  // Requester identity. Also the bit index of that port in a one-hot grant.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } portId_e;

  // Cycles spent in WAIT without m_ack before the watchdog aborts.
  localparam int DEFAULT_TIMEOUT = 255;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: two-way round-robin chooser for the fetch (I) and data (D) ports.
// grant is one-hot: bit 0 selects the fetch port, bit 1 the data port, and it
// is all-zero when nothing is requested. On a tie the port that was not granted
// last time wins, so lastGrant = PORT_D hands the tie to the fetch port.

module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       reqI,
  input  logic       reqD,
  input  logic       lastGrant,
  output logic [1:0] grant
);

  // Combinational winner selection from the two requests and the last winner.
  always_comb begin
    // NOTE: grant gets a default before any branch so every path assigns it and no latch is inferred.
    grant = 2'b00;
    if (reqI && reqD) begin
      grant = (lastGrant == PORT_D) ? 2'b01 : 2'b10;
    end else if (reqI) begin
      grant = 2'b01;
    end else if (reqD) begin
      grant = 2'b10;
    end
  end

endmodule : mem_arb_rr2

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between a fetch port (read only)
// and a data port (read/write). One transaction at a time: IDLE picks a winner
// round-robin and loads the m_* registers, WAIT holds them until m_ack, RESP
// pulses the winner's ack for one cycle with the captured read data.
//
// Build option: define MEM_ARB_TIMEOUT_EN to add a WAIT watchdog. After TIMEOUT
// WAIT cycles without m_ack the request is dropped, the port is acked with
// rdata 0 and err is set until reset. Without the macro err is tied low.

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // shared memory
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  // status
  output logic              busy,
  output logic              err
);

  arbState_e         state;
  portId_e           lastGrant;
  portId_e           curGrant;
  logic [1:0]        grant;
  logic              done;
  logic [DATA_W-1:0] respData;

  mem_arb_rr2 u_rr2 (
    .reqI      (i_req),
    .reqD      (d_req),
    .lastGrant (lastGrant),
    .grant     (grant)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  // Counter only has to reach TIMEOUT-1: the transaction leaves WAIT on that cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] waitCnt;
  logic             timeoutHit;
  logic             errFlag;

  assign timeoutHit = (state == WAIT) && (waitCnt == CNT_W'(TIMEOUT - 1));

  // Watchdog count: held at zero outside WAIT, so each WAIT starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
    end else if (state != WAIT) begin
      waitCnt <= '0;
    end else if (!m_ack && !timeoutHit) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  // Sticky error: set by a watchdog abort, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errFlag <= 1'b0;
    end else if (!m_ack && timeoutHit) begin
      errFlag <= 1'b1;
    end
  end

  assign err  = errFlag;
  assign done = m_ack || timeoutHit;
`else
  // No watchdog: WAIT ends only on m_ack. TIMEOUT is accepted and ignored.
  if (TIMEOUT < 1) begin : g_timeoutIgnored
  end

  assign err  = 1'b0;
  assign done = m_ack;
`endif

  // Data returned to the port: memory data on a real completion, zero on an abort.
  assign respData = m_ack ? m_rdata : '0;

  // Busy covers the whole transaction, from the grant until the ack cycle ends.
  assign busy = (state != IDLE);

  // Arbiter FSM with registered memory-side and port-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lastGrant <= PORT_D;
      curGrant  <= PORT_I;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register updates from pre-edge values.
      unique case (state)
        IDLE: begin
          if (grant[0]) begin
            // Fetch is read-only; m_wdata keeps its old value as a don't-care.
            curGrant  <= PORT_I;
            lastGrant <= PORT_I;
            m_we      <= 1'b0;
            m_addr    <= i_addr;
            m_req     <= 1'b1;
            state     <= WAIT;
          end else if (grant[1]) begin
            curGrant  <= PORT_D;
            lastGrant <= PORT_D;
            m_we      <= d_we;
            m_addr    <= d_addr;
            m_wdata   <= d_wdata;
            m_req     <= 1'b1;
            state     <= WAIT;
          end
        end

        WAIT: begin
          // m_* hold until the memory (or the watchdog) finishes the access.
          if (done) begin
            m_req <= 1'b0;
            state <= RESP;
            if (curGrant == PORT_I) begin
              i_rdata <= respData;
              i_ack   <= 1'b1;
            end else begin
              // A store completion leaves the load data untouched.
              if (!m_we) begin
                d_rdata <= respData;
              end
              d_ack <= 1'b1;
            end
          end
        end

        RESP: begin
          // Ack pulse ends here; pending requests are looked at in IDLE.
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end

        default: begin
          m_req <= 1'b0;
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_arbiter
